serial_sub: RTL and testbench
=============================

SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL provide parameter: W, default 8, operand width in bits (legal W >= 2).
REQ-002 SHALL provide port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL provide port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL provide port: start  input  1  request a subtraction; sampled only in IDLE.
REQ-005 SHALL provide port: a  input  W  minuend; captured on the accepting edge.
REQ-006 SHALL provide port: b  input  W  subtrahend; captured on the accepting edge.
REQ-007 SHALL provide port: busy  output  1  high while an operation is in progress (SHIFT or DONE).
REQ-008 SHALL provide port: done  output  1  single-cycle pulse; diff/bout valid.
REQ-009 SHALL provide port: diff  output  W  registered result, a - b modulo 2^W.
REQ-010 SHALL provide port: bout  output  1  registered final borrow; 1 iff a < b unsigned.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 SHALL, in IDLE with start=1 at a rising edge:
  - capture a and b into shift registers;
  - clear the borrow flop and the bit counter;
  - go to SHIFT.
REQ-013 SHALL, in IDLE with start=0, remain in IDLE.
REQ-014 SHALL, on each SHIFT edge:
  - compute one bit, LSB first, via the full-subtractor: d = x^y^bin, bnext = (~x&y) | (~(x^y)&bin);
  - shift d into diff from the MSB end;
  - register bnext;
  - increment the counter.
REQ-015 SHALL use borrow-in 0 for bit 0.
REQ-016 SHALL leave SHIFT for DONE on the edge that processes bit W-1, i.e. after exactly W SHIFT edges.
REQ-017 SHALL drive done=1 only in DONE, a Moore output exactly one cycle long.
REQ-018 SHALL go from DONE to IDLE unconditionally on the next edge.
REQ-019 SHALL make latency fixed: done is high in the cycle following the W-th edge after the accepting edge (cycle W+1 counting the accepting edge as 0).
REQ-020 SHALL drive busy=1 in SHIFT and DONE, and 0 in IDLE.
REQ-021 SHALL ignore start in SHIFT and DONE: no restart, no operand recapture.
REQ-022 SHALL accept start asserted in the first IDLE cycle after DONE (back-to-back operations allowed).
REQ-023 SHALL hold diff and bout stable from DONE until the next accepted start.
REQ-024 SHALL allow diff/bout to change only during SHIFT; their intermediate values in SHIFT are don't-care.
REQ-025 SHALL make results independent of a/b changes after the accepting edge.
REQ-026 SHALL compute all arithmetic unsigned, in W bits; there is no overflow flag.
REQ-027 SHALL size the counter to $clog2(W)+1 bits so W = 2^k does not wrap early.

Reset
REQ-028 SHALL, with rst=1 at a rising edge: state=IDLE, busy=0, done=0, diff=0, bout=0, counter=0, borrow=0.
REQ-029 SHALL give rst priority over start and over every FSM transition.
REQ-030 SHALL abort any operation in progress on rst mid-operation, with no done pulse.
REQ-031 SHALL, after rst is released, accept start on the first following edge.

Structure
REQ-032 SHALL place the state enum (IDLE, SHIFT, DONE) in shared package serial_sub_pkg.
REQ-033 SHALL place the default width constant (8) in serial_sub_pkg.
REQ-034 SHALL implement the per-bit logic as one combinational sub-module full_sub (x, y, bin -> d, bout), instantiated once.
REQ-035 SHALL use one sequential process for state, datapath and output registers.

Verification
REQ-036 SHALL cover: W=8, a=100, b=37 -> done one cycle, 9 edges after acceptance; diff=63, bout=0.
REQ-037 SHALL cover: a=37, b=100 -> diff=193, bout=1; a=0, b=1 -> diff=255, bout=1.
REQ-038 SHALL cover: a=255, b=255 -> diff=0, bout=0; a=0, b=0 -> diff=0, bout=0.
REQ-039 SHALL cover: start held high for 20 cycles with a=9, b=4, operands changed mid-operation -> first result diff=5, bout=0; a second operation starts the cycle after DONE using the then-current operands.
REQ-040 SHALL cover: rst asserted at the 4th SHIFT edge -> next cycle busy=0, done=0, diff=0, bout=0; no done pulse ever.
REQ-041 SHALL cover: W=4 build, a=3, b=5 -> diff=14, bout=1, done after 5 edges.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_sub_pkg;

  // Operand width used when the top is built without an override.
  localparam int SERIAL_SUB_DEFAULT_W = 8;

  // Controller states: waiting, one result bit per cycle, result-valid pulse.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bit counter width; one extra bit so that W = 2^k never wraps before W-1.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_sub_full_sub.sv
// One-bit full subtractor: d = x - y - bin, bout = borrow out.
// Latency: combinational.
// Backpressure: none.
module full_sub (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: diff = a - b mod 2^W, bout = (a < b), LSB first.
// Latency: fixed, done pulses W edges after the accepting edge.
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int W = SERIAL_SUB_DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout
);

  localparam int            CW   = cnt_width(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  diff_q, diff_d;
  logic          borrow_q, borrow_d;
  logic          bout_q, bout_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          bit_d;
  logic          bit_bout;

  // The operand shift registers present the current bit at position 0.
  full_sub u_full_sub (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (borrow_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // Next-state and datapath update; everything holds unless a state acts on it.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        diff_d   = {bit_d, diff_q[W-1:1]};
        borrow_d = bit_bout;
        // bout tracks the running borrow so it is final after bit W-1.
        bout_d   = bit_bout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Single register process for control, datapath and outputs; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: W=8 and W=4 instances share clock, reset, start and operands.
// Each instance has its own cycle-level reference model and scoreboard monitor.
// Stimulus: directed corner vectors, held start, mid-operation reset, then random traffic.
module tb_serial_sub;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : gen_w
    localparam int WW = (gi == 0) ? 8 : 4;

    logic          busy;
    logic          done;
    logic          bout;
    logic [WW-1:0] diff;

    serial_sub #(.W(WW)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a[WW-1:0]),
      .b     (b[WW-1:0]),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
    );

    // Reference: an accepted operation occupies WW+1 cycles after acceptance,
    // the last of which is the done cycle. Result is {borrow, difference}.
    logic [WW:0] exp_q[$];
    int          left = 0;
    logic [WW:0] cur  = '0;
    logic [WW:0] held = '0;
    logic [WW:0] popped;

    always @(posedge clk) begin
      int av;
      int bv;
      int dv;
      if (rst) begin
        left = 0;
        held = '0;
        exp_q.delete();
      end else if (left == 0 && start) begin
        av  = int'(a[WW-1:0]);
        bv  = int'(b[WW-1:0]);
        dv  = (av - bv + (1 << WW)) % (1 << WW);
        cur = {(av < bv), dv[WW-1:0]};
        exp_q.push_back(cur);
        left = WW + 1;
      end else if (left > 0) begin
        left--;
        if (left == 1) held = cur;
      end
    end

    // Monitor: per-cycle handshake check, and result pop whenever done is seen.
    always @(negedge clk) begin
      chk($sformatf("W%0d busy", WW), int'(busy), int'(left > 0));
      chk($sformatf("W%0d done", WW), int'(done), int'(left == 1));
      if (done) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("W%0d unexpected_done", WW), 1, 0);
        end else begin
          popped = exp_q.pop_front();
          chk($sformatf("W%0d diff", WW), int'(diff), int'(popped[WW-1:0]));
          chk($sformatf("W%0d bout", WW), int'(bout), int'(popped[WW]));
        end
      end else if (left == 0) begin
        chk($sformatf("W%0d idle_diff", WW), int'(diff), int'(held[WW-1:0]));
        chk($sformatf("W%0d idle_bout", WW), int'(bout), int'(held[WW]));
      end
    end
  end

  task automatic issue(input logic [7:0] av, input logic [7:0] bv);
    @(posedge clk); #1;
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Directed corner vectors (W=4 instance sees the low nibbles).
    issue(8'd100, 8'd37);
    issue(8'd37,  8'd100);
    issue(8'd0,   8'd1);
    issue(8'd255, 8'd255);
    issue(8'd0,   8'd0);
    issue(8'd3,   8'd5);

    // Start held for 20 cycles, operands changed mid-operation.
    @(posedge clk); #1;
    a = 8'd9;
    b = 8'd4;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    a = 8'($urandom_range(255));
    b = 8'($urandom_range(255));
    repeat (17) @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(posedge clk);

    // Reset sampled on the 4th SHIFT edge after acceptance.
    @(posedge clk); #1;
    a = 8'd200;
    b = 8'd13;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);

    // Random traffic: variable start length and gaps, occasional reset.
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      a = 8'($urandom_range(255));
      b = 8'($urandom_range(255));
      start = 1'b1;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
      start = 1'b0;
      a = 8'($urandom_range(255));
      b = 8'($urandom_range(255));
      if ($urandom_range(9) == 0) begin
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end
      repeat ($urandom_range(0, 12)) @(posedge clk);
    end

    repeat (15) @(posedge clk);
    chk("W8 pending_results", gen_w[0].exp_q.size(), 0);
    chk("W4 pending_results", gen_w[1].exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
